// File: rtl/reg_view_display.sv
// Register viewer: snapshots one of NUM_REGS registers (manual, auto-cycle or hold) and drives WIDTH/4 hex digits.
// Optional build macro REG_VIEW_BLANK_LEADING_EN blanks leading zero digits (digit 0 always lit).

module hex_to_sevenseg_decoder (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Active-low glyph lookup, bit0 = segment a .. bit6 = segment g
  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

module reg_view_display #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 9,
  parameter int SEL_W    = 4,
  parameter int DWELL    = 50_000_000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REGS*WIDTH-1:0] regs_flat,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      auto_en,
  input  logic                      freeze,
  output logic [WIDTH-1:0]          value,
  output logic [SEL_W-1:0]          cur_index,
  output logic [1:0]                state,
  output logic [(WIDTH/4)*7-1:0]    hex_flat
);

  localparam int DIGITS = WIDTH / 4;
  localparam int CNT_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_MANUAL = 2'b00,
    ST_AUTO   = 2'b01,
    ST_HOLD   = 2'b10
  } view_state_t;

  view_state_t      state_r;
  logic [SEL_W-1:0] idx_r;
  logic [WIDTH-1:0] value_r;
  logic [CNT_W-1:0] cnt_r;

  logic             sel_ok_s;
  logic [SEL_W-1:0] start_idx_s;
  logic [SEL_W-1:0] adv_idx_s;
  logic             dwell_end_s;

  // Indices at or beyond NUM_REGS read back as all ones
  function automatic logic [WIDTH-1:0] read_reg(input logic [SEL_W-1:0] idx);
    logic [WIDTH-1:0] res;
    res = {WIDTH{1'b1}};
    for (int i = 0; i < NUM_REGS; i++) begin
      res = ({1'b0, idx} == (SEL_W+1)'(i)) ? regs_flat[i*WIDTH +: WIDTH] : res;
    end
    return res;
  endfunction

  // Auto-mode entry index, wrap-around advance and dwell terminal count
  always_comb begin
    sel_ok_s    = ({1'b0, sel} < (SEL_W+1)'(NUM_REGS));
    start_idx_s = sel_ok_s ? sel : {SEL_W{1'b0}};
    adv_idx_s   = ({1'b0, idx_r} >= (SEL_W+1)'(NUM_REGS - 1)) ? {SEL_W{1'b0}}
                                                               : idx_r + SEL_W'(1);
    dwell_end_s = (cnt_r == DWELL_LAST);
  end

  // Viewer FSM: freeze beats auto_en beats manual; HOLD leaves every register untouched
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_MANUAL;
      idx_r   <= {SEL_W{1'b0}};
      value_r <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else if (freeze) begin
      state_r <= ST_HOLD;
    end else if (auto_en) begin
      state_r <= ST_AUTO;
      case (state_r)
        ST_AUTO, ST_HOLD: begin
          // Leaving HOLD resumes the dwell count where it stopped
          if (dwell_end_s) begin
            cnt_r   <= {CNT_W{1'b0}};
            idx_r   <= adv_idx_s;
            value_r <= read_reg(adv_idx_s);
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
            value_r <= read_reg(idx_r);
          end
        end
        default: begin
          cnt_r   <= {CNT_W{1'b0}};
          idx_r   <= start_idx_s;
          value_r <= read_reg(start_idx_s);
        end
      endcase
    end else begin
      state_r <= ST_MANUAL;
      idx_r   <= sel;
      value_r <= read_reg(sel);
      cnt_r   <= {CNT_W{1'b0}};
    end
  end

  assign value     = value_r;
  assign cur_index = idx_r;
  assign state     = state_r;

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    logic [6:0] seg_s;

    hex_to_sevenseg_decoder u_dec (
      .nibble (value_r[d*4 +: 4]),
      .seg    (seg_s)
    );

`ifdef REG_VIEW_BLANK_LEADING_EN
    if (d == 0) begin : g_lsd
      assign hex_flat[6:0] = seg_s;
    end else begin : g_blank
      assign hex_flat[d*7 +: 7] = (~|value_r[WIDTH-1:d*4]) ? 7'h7F : seg_s;
    end
`else
    assign hex_flat[d*7 +: 7] = seg_s;
`endif
  end

endmodule

// File: tb/tb_reg_view_display.sv
// Scoreboard bench for reg_view_display (WIDTH=16, NUM_REGS=9, SEL_W=4, DWELL=4).
// The driver queues hand-derived expectations; a monitor pops one per clock and compares.

module tb_reg_view_display;

  localparam logic [3:0] NO_WR = 4'hF;

  typedef struct packed {
    logic [15:0] v;
    logic [3:0]  i;
    logic [1:0]  s;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset;
  logic [143:0] regs_flat;
  logic [3:0]   sel;
  logic         auto_en;
  logic         freeze;
  logic [15:0]  value;
  logic [3:0]   cur_index;
  logic [1:0]   state;
  logic [27:0]  hex_flat;

  logic [15:0]  regs [9];
  exp_t         exp_q [$];
  exp_t         e;
  int           checks = 0;
  int           errors = 0;

  reg_view_display #(
    .WIDTH    (16),
    .NUM_REGS (9),
    .SEL_W    (4),
    .DWELL    (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .regs_flat (regs_flat),
    .sel       (sel),
    .auto_en   (auto_en),
    .freeze    (freeze),
    .value     (value),
    .cur_index (cur_index),
    .state     (state),
    .hex_flat  (hex_flat)
  );

  always #5 clock = ~clock;

  always_comb begin
    regs_flat = '0;
    for (int k = 0; k < 9; k++) regs_flat[k*16 +: 16] = regs[k];
  end

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h40;  4'h1: g = 7'h79;  4'h2: g = 7'h24;  4'h3: g = 7'h30;
      4'h4: g = 7'h19;  4'h5: g = 7'h12;  4'h6: g = 7'h02;  4'h7: g = 7'h78;
      4'h8: g = 7'h00;  4'h9: g = 7'h10;  4'hA: g = 7'h08;  4'hB: g = 7'h03;
      4'hC: g = 7'h46;  4'hD: g = 7'h21;  4'hE: g = 7'h06;  default: g = 7'h0E;
    endcase
    return g;
  endfunction

  function automatic logic [27:0] exp_hex(input logic [15:0] v);
    logic [27:0] h;
    for (int d = 0; d < 4; d++) begin
      h[d*7 +: 7] = glyph(v[d*4 +: 4]);
`ifdef REG_VIEW_BLANK_LEADING_EN
      if (d > 0 && (v >> (d*4)) == 16'h0000) h[d*7 +: 7] = 7'h7F;
`endif
    end
    return h;
  endfunction

  // One clock: drive inputs at negedge, optionally rewrite one register, queue the post-edge result
  task automatic step(input logic r, input logic [3:0] s, input logic a, input logic f,
                      input logic [3:0] wi, input logic [15:0] wd,
                      input logic [15:0] ev, input logic [3:0] ei, input logic [1:0] es);
    @(negedge clock);
    reset   = r;
    sel     = s;
    auto_en = a;
    freeze  = f;
    if (wi != NO_WR) regs[wi] = wd;
    exp_q.push_back('{v: ev, i: ei, s: es});
  endtask

  // Monitor: outputs are valid one clock after each driven cycle
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (value !== e.v) begin
          errors++;
          $display("FAIL value @%0t: got %h expected %h", $time, value, e.v);
        end
        checks++;
        if (cur_index !== e.i) begin
          errors++;
          $display("FAIL cur_index @%0t: got %0d expected %0d", $time, cur_index, e.i);
        end
        checks++;
        if (state !== e.s) begin
          errors++;
          $display("FAIL state @%0t: got %b expected %b", $time, state, e.s);
        end
        checks++;
        if (hex_flat !== exp_hex(e.v)) begin
          errors++;
          $display("FAIL hex_flat @%0t: got %h expected %h", $time, hex_flat, exp_hex(e.v));
        end
      end
    end
  end

  initial begin
    int wait_cnt;
    reset = 1'b1; sel = 4'd0; auto_en = 1'b0; freeze = 1'b0;
    regs[0] = 16'h00A3; regs[1] = 16'h0001; regs[2] = 16'hBEEF;
    regs[3] = 16'h1234; regs[4] = 16'h0000; regs[5] = 16'h5A5A;
    regs[6] = 16'hF00D; regs[7] = 16'h7777; regs[8] = 16'h8888;

    // reset, including priority over freeze/auto
    step(1'b1, 4'd3, 1'b0, 1'b0, NO_WR, 16'h0, 16'h0000, 4'd0, 2'b00);
    step(1'b1, 4'd3, 1'b1, 1'b1, NO_WR, 16'h0, 16'h0000, 4'd0, 2'b00);
    // manual select, out-of-range, zero-padded values
    step(1'b0, 4'd3,  1'b0, 1'b0, NO_WR, 16'h0, 16'h1234, 4'd3,  2'b00);
    step(1'b0, 4'd12, 1'b0, 1'b0, NO_WR, 16'h0, 16'hFFFF, 4'd12, 2'b00);
    step(1'b0, 4'd0,  1'b0, 1'b0, NO_WR, 16'h0, 16'h00A3, 4'd0,  2'b00);
    step(1'b0, 4'd4,  1'b0, 1'b0, NO_WR, 16'h0, 16'h0000, 4'd4,  2'b00);
    // auto from sel=7: four cycles on 7, four on 8 (R8 changes live), wrap to 0
    step(1'b0, 4'd7, 1'b1, 1'b0, NO_WR, 16'h0, 16'h7777, 4'd7, 2'b01);
    step(1'b0, 4'd2, 1'b1, 1'b0, NO_WR, 16'h0, 16'h7777, 4'd7, 2'b01);
    step(1'b0, 4'd2, 1'b1, 1'b0, NO_WR, 16'h0, 16'h7777, 4'd7, 2'b01);
    step(1'b0, 4'd2, 1'b1, 1'b0, NO_WR, 16'h0, 16'h7777, 4'd7, 2'b01);
    step(1'b0, 4'd2, 1'b1, 1'b0, NO_WR, 16'h0, 16'h8888, 4'd8, 2'b01);
    step(1'b0, 4'd2, 1'b1, 1'b0, 4'd8, 16'h8001, 16'h8001, 4'd8, 2'b01);
    step(1'b0, 4'd2, 1'b1, 1'b0, NO_WR, 16'h0, 16'h8001, 4'd8, 2'b01);
    step(1'b0, 4'd2, 1'b1, 1'b0, NO_WR, 16'h0, 16'h8001, 4'd8, 2'b01);
    step(1'b0, 4'd2, 1'b1, 1'b0, NO_WR, 16'h0, 16'h00A3, 4'd0, 2'b01);
    step(1'b0, 4'd2, 1'b1, 1'b0, NO_WR, 16'h0, 16'h00A3, 4'd0, 2'b01);
    step(1'b0, 4'd2, 1'b1, 1'b0, NO_WR, 16'h0, 16'h00A3, 4'd0, 2'b01);
    // freeze with dwell counter at 2 for ten cycles while R0 changes
    step(1'b0, 4'd2, 1'b1, 1'b1, 4'd0, 16'hDEAD, 16'h00A3, 4'd0, 2'b10);
    for (int k = 0; k < 9; k++) begin
      if (k == 3) step(1'b0, 4'd2, 1'b1, 1'b1, 4'd0, 16'h0BAD, 16'h00A3, 4'd0, 2'b10);
      else        step(1'b0, 4'd2, 1'b1, 1'b1, NO_WR, 16'h0,   16'h00A3, 4'd0, 2'b10);
    end
    // release: counter 2 -> 3, then wrap and advance
    step(1'b0, 4'd2, 1'b1, 1'b0, NO_WR, 16'h0, 16'h0BAD, 4'd0, 2'b01);
    step(1'b0, 4'd2, 1'b1, 1'b0, NO_WR, 16'h0, 16'h0001, 4'd1, 2'b01);
    // back to manual, boundary indices 9 and 8
    step(1'b0, 4'd6, 1'b0, 1'b0, NO_WR, 16'h0, 16'hF00D, 4'd6, 2'b00);
    step(1'b0, 4'd9, 1'b0, 1'b0, NO_WR, 16'h0, 16'hFFFF, 4'd9, 2'b00);
    step(1'b0, 4'd8, 1'b0, 1'b0, NO_WR, 16'h0, 16'h8001, 4'd8, 2'b00);
    // freeze and auto together from manual; sel change ignored in hold
    step(1'b0, 4'd8, 1'b1, 1'b1, NO_WR, 16'h0, 16'h8001, 4'd8, 2'b10);
    step(1'b0, 4'd5, 1'b0, 1'b1, NO_WR, 16'h0, 16'h8001, 4'd8, 2'b10);
    step(1'b0, 4'd5, 1'b0, 1'b0, NO_WR, 16'h0, 16'h5A5A, 4'd5, 2'b00);
    // auto entry with out-of-range sel starts at 0
    step(1'b0, 4'd12, 1'b1, 1'b0, NO_WR, 16'h0, 16'h0BAD, 4'd0, 2'b01);
    step(1'b0, 4'd12, 1'b1, 1'b0, NO_WR, 16'h0, 16'h0BAD, 4'd0, 2'b01);
    // reset mid-dwell, then reset from hold
    step(1'b1, 4'd12, 1'b1, 1'b0, NO_WR, 16'h0, 16'h0000, 4'd0, 2'b00);
    step(1'b0, 4'd2,  1'b0, 1'b0, NO_WR, 16'h0, 16'hBEEF, 4'd2, 2'b00);
    step(1'b0, 4'd7,  1'b0, 1'b1, NO_WR, 16'h0, 16'hBEEF, 4'd2, 2'b10);
    step(1'b1, 4'd7,  1'b0, 1'b1, NO_WR, 16'h0, 16'h0000, 4'd0, 2'b00);
    step(1'b0, 4'd1,  1'b0, 1'b0, NO_WR, 16'h0, 16'h0001, 4'd1, 2'b00);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clock);
      wait_cnt++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
